// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
// The FSM has exactly two states; the default word width lives here so the top and bench agree.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serializer_pkg

// File: rtl/bit_cnt.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1 and flags the last position.
// Saturates at the terminal count so it can never step past WIDTH-1.
module bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule : bit_cnt

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready word interface and a registered bit stream.
// A new word may be loaded on the last-bit cycle so consecutive words stream without a gap.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q_out,
  output logic             q_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_q_out;
  logic             r_q_valid;
  logic             r_busy;

  logic [CW-1:0]    w_cnt;
  logic             w_tc;
  logic             w_last;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shreg_next;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign w_last       = (r_state == SHIFT) && w_tc;
  assign din_ready    = (r_state == IDLE) || w_last;
  assign w_xfer       = din_valid && din_ready;
  assign w_shreg_next = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

  // The counter restarts on every load and when the word finishes without a successor.
  bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_xfer || w_last),
    .i_en    (r_state == SHIFT),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // Reset outranks a transfer presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_q_out   <= 1'b0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_xfer) begin
      r_state   <= SHIFT;
      r_shreg   <= din;
      r_q_out   <= head_bit(din);
      r_q_valid <= 1'b1;
      r_busy    <= 1'b1;
    end else if (w_last) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_q_out   <= 1'b0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_shreg   <= w_shreg_next;
      r_q_out   <= head_bit(w_shreg_next);
    end
  end

  assign q_out   = r_q_out;
  assign q_valid = r_q_valid;
  assign busy    = r_busy;

endmodule : bit_serializer
